panel_image_loader: RTL and testbench

//  Synthesizable front-panel sequencer. Copies a memory image into the PDP-8

---
 rtl/panel_image_loader_pkg.sv | 23 ++
 rtl/panel_image_loader_if.sv | 32 +++
 rtl/panel_press_timer.sv | 108 ++++++++++
 rtl/panel_image_loader.sv | 185 ++++++++++++++++++
 tb/tb_panel_image_loader.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/panel_image_loader_pkg.sv
// Shared types and constants for the front-panel image loader.
package panel_image_loader_pkg;

  // Loader FSM encoding; kept as plain constants so legacy tools can read state dumps.
  typedef logic [2:0] loader_state_t;
  localparam loader_state_t StIdle      = 3'd0;
  localparam loader_state_t StFetch     = 3'd1;
  localparam loader_state_t StRdWait    = 3'd2;
  localparam loader_state_t StActLdpc   = 3'd3;
  localparam loader_state_t StActDep    = 3'd4;
  localparam loader_state_t StNext      = 3'd5;
  localparam loader_state_t StFinalLdpc = 3'd6;
  localparam loader_state_t StEnd       = 3'd7;

  // Which panel button a press action drives.
  typedef enum logic {
    BtnLdpc = 1'b0,
    BtnDep  = 1'b1
  } panel_btn_t;

  localparam int unsigned PanelHoldDefault = 10;

endpackage

// File: rtl/panel_image_loader_if.sv
// Host/ROM/panel signal bundle for the image loader.
// master: the loader itself. slave: the host side (job requester, image ROM, panel).
interface panel_image_loader_if #(
  parameter int unsigned WORD_W = 12,
  parameter int unsigned ADDR_W = 12
);
  logic              start;
  logic              skip_zero;
  logic              auto_run;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic [ADDR_W-1:0] run_addr;
  logic [ADDR_W-1:0] img_addr;
  logic [WORD_W-1:0] img_data;
  logic [WORD_W-1:0] sw_data;
  logic              load_pc;
  logic              deposit;
  logic              run;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   deposits;

  modport master (
    input  start, skip_zero, auto_run, base_addr, word_count, run_addr, img_data,
    output img_addr, sw_data, load_pc, deposit, run, busy, done, deposits
  );

  modport slave (
    output start, skip_zero, auto_run, base_addr, word_count, run_addr, img_data,
    input  img_addr, sw_data, load_pc, deposit, run, busy, done, deposits
  );
endinterface

// File: rtl/panel_press_timer.sv
// One panel action: SETUP -> PRESS -> RELEASE, HOLD cycles each.
// sw_data is latched on go and held until the next go, so it is stable around the press.
module panel_press_timer
  import panel_image_loader_pkg::*;
#(
  parameter int unsigned WORD_W = 12,
  parameter int unsigned HOLD   = PanelHoldDefault
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              go_i,
  input  panel_btn_t        btn_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] sw_data_o,
  output logic              load_pc_o,
  output logic              deposit_o,
  output logic              press_o,   // last SETUP cycle: button rises on next edge
  output logic              ack_o      // last RELEASE cycle
);

  localparam int unsigned CntW = $clog2(HOLD + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(HOLD - 1);

  typedef enum logic [1:0] {PhIdle, PhSetup, PhPress, PhRelease} phase_e;

  phase_e            phase_q, phase_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  panel_btn_t        btn_q, btn_d;
  logic [WORD_W-1:0] sw_q, sw_d;
  logic              load_pc_q, load_pc_d;
  logic              deposit_q, deposit_d;
  logic              last;

  assign last      = (cnt_q == LastCnt);
  assign ack_o     = (phase_q == PhRelease) && last;
  assign press_o   = (phase_q == PhSetup) && last;
  assign sw_data_o = sw_q;
  assign load_pc_o = load_pc_q;
  assign deposit_o = deposit_q;

  // Phase sequencing; a new go may arrive in idle or on the ack cycle.
  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    btn_d     = btn_q;
    sw_d      = sw_q;
    load_pc_d = load_pc_q;
    deposit_d = deposit_q;
    unique case (phase_q)
      PhIdle: ;
      PhSetup: begin
        if (last) begin
          phase_d   = PhPress;
          cnt_d     = '0;
          load_pc_d = (btn_q == BtnLdpc);
          deposit_d = (btn_q == BtnDep);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PhPress: begin
        if (last) begin
          phase_d   = PhRelease;
          cnt_d     = '0;
          load_pc_d = 1'b0;
          deposit_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PhRelease: begin
        if (last) begin
          phase_d = PhIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: phase_d = PhIdle;
    endcase
    if (go_i) begin
      phase_d = PhSetup;
      cnt_d   = '0;
      btn_d   = btn_i;
      sw_d    = data_i;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q   <= PhIdle;
      cnt_q     <= '0;
      btn_q     <= BtnLdpc;
      sw_q      <= '0;
      load_pc_q <= 1'b0;
      deposit_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      btn_q     <= btn_d;
      sw_q      <= sw_d;
      load_pc_q <= load_pc_d;
      deposit_q <= deposit_d;
    end
  end

endmodule

// File: rtl/panel_image_loader.sv
// Front-panel sequencer: copies an image into the PDP-8 via Load PC / Deposit presses,
// finishes with a Load PC of run_addr and optionally raises the run switch.
module panel_image_loader
  import panel_image_loader_pkg::*;
#(
  parameter int unsigned WORD_W = 12,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned HOLD   = PanelHoldDefault
) (
  input  logic                  clk,
  input  logic                  btnCpuReset,
  panel_image_loader_if.master  bus
);

  localparam logic [ADDR_W:0] RemOne = (ADDR_W + 1)'(1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W-1:0] run_addr_q, run_addr_d;
  logic              skip_q, skip_d;
  logic              auto_q, auto_d;
  logic              reload_q, reload_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              run_q, run_d;
  logic [ADDR_W:0]   deposits_q, deposits_d;

  logic              go;
  panel_btn_t        go_btn;
  logic [WORD_W-1:0] go_data;
  logic              press;
  logic              ack;

  panel_press_timer #(
    .WORD_W (WORD_W),
    .HOLD   (HOLD)
  ) u_timer (
    .clk_i     (clk),
    .rst_ni    (btnCpuReset),
    .go_i      (go),
    .btn_i     (go_btn),
    .data_i    (go_data),
    .sw_data_o (bus.sw_data),
    .load_pc_o (bus.load_pc),
    .deposit_o (bus.deposit),
    .press_o   (press),
    .ack_o     (ack)
  );

  assign bus.img_addr = cur_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.run      = run_q;
  assign bus.deposits = deposits_q;

  // Job sequencing; go launches the next panel action so it starts on state entry.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    rem_d      = rem_q;
    run_addr_d = run_addr_q;
    skip_d     = skip_q;
    auto_d     = auto_q;
    reload_d   = reload_q;
    word_d     = word_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    run_d      = run_q;
    deposits_d = deposits_q;
    go         = 1'b0;
    go_btn     = BtnLdpc;
    go_data    = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          cur_d      = bus.base_addr;
          rem_d      = bus.word_count;
          run_addr_d = bus.run_addr;
          skip_d     = bus.skip_zero;
          auto_d     = bus.auto_run;
          reload_d   = 1'b1;
          busy_d     = 1'b1;
          run_d      = 1'b0;
          deposits_d = '0;
          state_d    = StFetch;
        end
      end
      StFetch: begin
        // Only an empty job reaches here with nothing left.
        if (rem_q == '0) begin
          go      = 1'b1;
          go_data = WORD_W'(run_addr_q);
          state_d = StFinalLdpc;
        end else begin
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        word_d = bus.img_data;
        if (skip_q && (bus.img_data == '0)) begin
          reload_d = 1'b1;
          state_d  = StNext;
        end else if (reload_q) begin
          go      = 1'b1;
          go_data = WORD_W'(cur_q);
          state_d = StActLdpc;
        end else begin
          go      = 1'b1;
          go_btn  = BtnDep;
          go_data = bus.img_data;
          state_d = StActDep;
        end
      end
      StActLdpc: begin
        if (ack) begin
          reload_d = 1'b0;
          go       = 1'b1;
          go_btn   = BtnDep;
          go_data  = word_q;
          state_d  = StActDep;
        end
      end
      StActDep: begin
        if (press) deposits_d = deposits_q + 1'b1;
        if (ack) state_d = StNext;
      end
      StNext: begin
        // PC wraps exactly like cur, so no reload is needed at the address wrap.
        cur_d = cur_q + 1'b1;
        rem_d = rem_q - 1'b1;
        if (rem_q == RemOne) begin
          go      = 1'b1;
          go_data = WORD_W'(run_addr_q);
          state_d = StFinalLdpc;
        end else begin
          state_d = StFetch;
        end
      end
      StFinalLdpc: begin
        if (ack) state_d = StEnd;
      end
      StEnd: begin
        run_d   = auto_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Loader state registers.
  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      state_q    <= StIdle;
      cur_q      <= '0;
      rem_q      <= '0;
      run_addr_q <= '0;
      skip_q     <= 1'b0;
      auto_q     <= 1'b0;
      reload_q   <= 1'b0;
      word_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      run_q      <= 1'b0;
      deposits_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      rem_q      <= rem_d;
      run_addr_q <= run_addr_d;
      skip_q     <= skip_d;
      auto_q     <= auto_d;
      reload_q   <= reload_d;
      word_q     <= word_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      run_q      <= run_d;
      deposits_q <= deposits_d;
    end
  end

endmodule

// File: tb/tb_panel_image_loader.sv
// Scoreboard bench for panel_image_loader: expected panel actions and job results are
// queued by the stimulus; a negedge monitor pops and compares as the DUT produces them.
module tb_panel_image_loader;
  import panel_image_loader_pkg::*;

  localparam int unsigned WordW = 12;
  localparam int unsigned AddrW = 12;
  localparam int unsigned Hold  = 2;

  typedef struct packed {
    logic        is_dep;
    logic [11:0] data;
  } act_t;

  typedef struct {
    int   deps;
    logic run;
    int   busy_cyc;  // -1: not checked
  } job_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  panel_image_loader_if #(.WORD_W(WordW), .ADDR_W(AddrW)) bus ();

  panel_image_loader #(
    .WORD_W (WordW),
    .ADDR_W (AddrW),
    .HOLD   (Hold)
  ) dut (
    .clk         (clk),
    .btnCpuReset (rst_n),
    .bus         (bus)
  );

  logic [11:0] mem [4096];
  always @(posedge clk) bus.img_data <= mem[bus.img_addr];

  act_t        act_q[$];
  job_t        job_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          done_seen = 0;
  int          exp_deps = 0;
  int          busy_cnt = 0;
  logic        prev_btn = 1'b0;
  logic [11:0] prev_sw = '0;
  act_t        m_act;
  job_t        m_job;

  // Monitor: checks every action on its press edge and every job on its done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_btn = 1'b0;
      busy_cnt = 0;
    end else begin
      vectors++;
      if (bus.load_pc && bus.deposit) begin
        miscompares++;
        $display("FAIL both_buttons load_pc=%b deposit=%b, required at most one", bus.load_pc,
                 bus.deposit);
      end
      if ((bus.load_pc || bus.deposit) && prev_btn) begin
        vectors++;
        if (bus.sw_data !== prev_sw) begin
          miscompares++;
          $display("FAIL sw_stable sw_data=%o, required %o", bus.sw_data, prev_sw);
        end
      end
      if ((bus.load_pc || bus.deposit) && !prev_btn) begin
        vectors++;
        if (act_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_action dep=%b sw=%o, required no action", bus.deposit,
                   bus.sw_data);
        end else begin
          m_act = act_q.pop_front();
          if (bus.deposit !== m_act.is_dep || bus.sw_data !== m_act.data) begin
            miscompares++;
            $display("FAIL action dep=%b sw=%o, required dep=%b sw=%o", bus.deposit,
                     bus.sw_data, m_act.is_dep, m_act.data);
          end
          if (bus.deposit) begin
            exp_deps++;
            vectors++;
            if (bus.deposits !== 13'(exp_deps)) begin
              miscompares++;
              $display("FAIL deposits_at_press deposits=%0d, required %0d", bus.deposits,
                       exp_deps);
            end
          end
        end
      end
      prev_btn = bus.load_pc || bus.deposit;
      prev_sw  = bus.sw_data;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_seen++;
        vectors++;
        if (job_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done done=1, required no done");
        end else begin
          m_job = job_q.pop_front();
          if (bus.deposits !== 13'(m_job.deps) || bus.run !== m_job.run || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL job_end deposits=%0d run=%b busy=%b, required %0d %b 0",
                     bus.deposits, bus.run, bus.busy, m_job.deps, m_job.run);
          end
          if (m_job.busy_cyc >= 0) begin
            vectors++;
            if (busy_cnt != m_job.busy_cyc) begin
              miscompares++;
              $display("FAIL busy_len cycles=%0d, required %0d", busy_cnt, m_job.busy_cyc);
            end
          end
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic exp_act(input logic d, input logic [11:0] v);
    act_t a;
    a.is_dep = d;
    a.data   = v;
    act_q.push_back(a);
  endtask

  task automatic exp_job(input int deps, input logic r, input int bc);
    job_t j;
    j.deps     = deps;
    j.run      = r;
    j.busy_cyc = bc;
    job_q.push_back(j);
  endtask

  task automatic set_job(input logic [11:0] base, input logic [12:0] cnt,
                         input logic [11:0] ra, input logic skip, input logic ar);
    bus.base_addr  = base;
    bus.word_count = cnt;
    bus.run_addr   = ra;
    bus.skip_zero  = skip;
    bus.auto_run   = ar;
  endtask

  task automatic start_job(input logic [11:0] base, input logic [12:0] cnt,
                           input logic [11:0] ra, input logic skip, input logic ar);
    @(negedge clk);
    set_job(base, cnt, ra, skip, ar);
    exp_deps  = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int n;
    n = 0;
    while (done_seen == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (done_seen == d0) begin
      miscompares++;
      $display("FAIL %s_timeout done_seen=%0d, required %0d", name, done_seen, d0 + 1);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s got=%0o, required %0o", name, act, req);
    end
  endtask

  task automatic load_t1;
    mem[12'o0200] = 12'o0001;
    mem[12'o0201] = 12'o0002;
    mem[12'o0202] = 12'o0003;
    exp_act(1'b0, 12'o0200);
    exp_act(1'b1, 12'o0001);
    exp_act(1'b1, 12'o0002);
    exp_act(1'b1, 12'o0003);
    exp_act(1'b0, 12'o0400);
  endtask

  initial begin
    int d0;
    int n;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    bus.start = 1'b0;
    set_job('0, '0, '0, 1'b0, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 13'(bus.busy), 13'd0);
    check("rst_done", 13'(bus.done), 13'd0);
    check("rst_run", 13'(bus.run), 13'd0);
    check("rst_deposits", bus.deposits, 13'd0);
    check("rst_buttons", 13'({bus.load_pc, bus.deposit}), 13'd0);
    check("rst_sw", 13'(bus.sw_data), 13'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: three-word image
    load_t1();
    exp_job(3, 1'b0, -1);
    d0 = done_seen;
    start_job(12'o0200, 13'd3, 12'o0400, 1'b0, 1'b0);
    check("t1_busy", 13'(bus.busy), 13'd1);
    wait_done(d0, 200, "t1");

    // T2: skip zero words, re-address with Load PC
    mem[0] = 12'o0005; mem[1] = '0; mem[2] = '0; mem[3] = 12'o0007;
    exp_act(1'b0, 12'o0000);
    exp_act(1'b1, 12'o0005);
    exp_act(1'b0, 12'o0003);
    exp_act(1'b1, 12'o0007);
    exp_act(1'b0, 12'o0017);
    exp_job(2, 1'b0, -1);
    d0 = done_seen;
    start_job(12'o0000, 13'd4, 12'o0017, 1'b1, 1'b0);
    wait_done(d0, 200, "t2");

    // T3: empty job, auto run, busy for 3*HOLD+2 cycles
    exp_act(1'b0, 12'o0200);
    exp_job(0, 1'b1, 3 * Hold + 2);
    d0 = done_seen;
    start_job(12'o0000, 13'd0, 12'o0200, 1'b0, 1'b1);
    wait_done(d0, 100, "t3");
    repeat (5) @(negedge clk);
    check("t3_run_held", 13'(bus.run), 13'd1);

    // T4: address wrap, single Load PC
    mem[12'o7776] = 12'o0011; mem[12'o7777] = 12'o0022;
    mem[12'o0000] = 12'o0033; mem[12'o0001] = 12'o0044;
    exp_act(1'b0, 12'o7776);
    exp_act(1'b1, 12'o0011);
    exp_act(1'b1, 12'o0022);
    exp_act(1'b1, 12'o0033);
    exp_act(1'b1, 12'o0044);
    exp_act(1'b0, 12'o0200);
    exp_job(4, 1'b0, -1);
    d0 = done_seen;
    start_job(12'o7776, 13'd4, 12'o0200, 1'b0, 1'b0);
    check("t4_run_cleared", 13'(bus.run), 13'd0);
    wait_done(d0, 200, "t4");

    // T5: asynchronous reset during a Deposit press
    load_t1();
    exp_job(3, 1'b0, -1);
    d0 = done_seen;
    start_job(12'o0200, 13'd3, 12'o0400, 1'b0, 1'b0);
    n = 0;
    while (!bus.deposit && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_reached_press", 13'(bus.deposit), 13'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_deposit_async", 13'(bus.deposit), 13'd0);
    check("t5_busy_async", 13'(bus.busy), 13'd0);
    check("t5_deposits_async", bus.deposits, 13'd0);
    act_q.delete();
    job_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_no_done", 13'(done_seen - d0), 13'd0);
    load_t1();
    exp_job(3, 1'b0, -1);
    d0 = done_seen;
    start_job(12'o0200, 13'd3, 12'o0400, 1'b0, 1'b0);
    wait_done(d0, 200, "t5_rerun");

    // T6: start held high for the whole job
    load_t1();
    exp_job(3, 1'b0, -1);
    d0 = done_seen;
    @(negedge clk);
    set_job(12'o0200, 13'd3, 12'o0400, 1'b0, 1'b0);
    exp_deps  = 0;
    bus.start = 1'b1;
    n = 0;
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    check("t6_one_done", 13'(done_seen - d0), 13'd1);
    check("t6_idle", 13'(bus.busy), 13'd0);

    check("queues_drained", 13'(act_q.size() + job_q.size()), 13'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
